// File: rtl/crc32_pkg.sv
// Shared constants for the CRC32 datapath and its buffering FIFOs.
package crc32_pkg;

    localparam int CRC_DATA_W            = 32;
    localparam int FIFO_ADDR_W_DEFAULT   = 5;
    localparam int FIFO_AF_LEVEL_DEFAULT = 28;
    localparam int FIFO_AE_LEVEL_DEFAULT = 4;

endpackage : crc32_pkg

// File: rtl/fifo_dpram.sv
// DEPTH x DATA_W register file: synchronous write port, asynchronous read
// port. Contents are intentionally not reset; the owning FIFO's pointers
// decide which entries are valid.
module fifo_dpram #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clock,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Store the incoming word on an accepted write.
    always_ff @(posedge clock) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Combinational read so the head word is available with zero latency.
    assign rdata_o = mem_q[raddr_i];

endmodule : fifo_dpram

// File: rtl/synch_fifo_param.sv
// First-word-fall-through synchronous FIFO with occupancy count,
// almost-full/almost-empty thresholds, synchronous flush and sticky
// overflow/underflow flags. Pointers carry one extra wrap bit so that
// full and empty are distinguishable without a separate counter.
module synch_fifo_param
    import crc32_pkg::*;
#(
    parameter int DATA_W   = CRC_DATA_W,
    parameter int ADDR_W   = FIFO_ADDR_W_DEFAULT,
    parameter int AF_LEVEL = FIFO_AF_LEVEL_DEFAULT,
    parameter int AE_LEVEL = FIFO_AE_LEVEL_DEFAULT
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              flush,
    input  logic              wen,
    input  logic [DATA_W-1:0] wdata,
    input  logic              ren,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [ADDR_W:0] AF_CNT = (ADDR_W+1)'(AF_LEVEL);
    localparam logic [ADDR_W:0] AE_CNT = (ADDR_W+1)'(AE_LEVEL);

    logic [ADDR_W:0]   wptr_q, wptr_d;
    logic [ADDR_W:0]   rptr_q, rptr_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;
    logic              wr_accept;
    logic              rd_accept;
    logic [DATA_W-1:0] ram_rdata;

    // Status flags derive purely from the registered pointers.
    assign empty        = (wptr_q == rptr_q);
    assign full         = (wptr_q[ADDR_W-1:0] == rptr_q[ADDR_W-1:0]) &&
                          (wptr_q[ADDR_W] != rptr_q[ADDR_W]);
    assign count        = wptr_q - rptr_q;
    assign almost_full  = (count >= AF_CNT);
    assign almost_empty = (count <= AE_CNT);
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

    // Flush outranks both requests; full/empty are the pre-edge values,
    // so a read on a full FIFO frees no room for a same-cycle write.
    assign wr_accept = wen && !full && !flush;
    assign rd_accept = ren && !empty && !flush;

    // Head word is forced to zero when nothing is queued.
    assign rdata = empty ? '0 : ram_rdata;

    fifo_dpram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clock   (clock),
        .we_i    (wr_accept),
        .waddr_i (wptr_q[ADDR_W-1:0]),
        .wdata_i (wdata),
        .raddr_i (rptr_q[ADDR_W-1:0]),
        .rdata_o (ram_rdata)
    );

    // Next-state pointers and sticky error flags.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        ovf_d  = ovf_q;
        udf_d  = udf_q;
        if (flush) begin
            wptr_d = '0;
            rptr_d = '0;
            ovf_d  = 1'b0;
            udf_d  = 1'b0;
        end else begin
            if (wr_accept) wptr_d = wptr_q + 1'b1;
            if (rd_accept) rptr_d = rptr_q + 1'b1;
            if (wen && full)  ovf_d = 1'b1;
            if (ren && empty) udf_d = 1'b1;
        end
    end

    // Pointer and flag registers; reset empties the FIFO immediately.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wptr_q <= '0;
            rptr_q <= '0;
            ovf_q  <= 1'b0;
            udf_q  <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            ovf_q  <= ovf_d;
            udf_q  <= udf_d;
        end
    end

endmodule : synch_fifo_param

// File: tb/tb_synch_fifo_param.sv
// Directed bench for synch_fifo_param with a queue-based reference model
// checked against every output on each falling clock edge.
module tb_synch_fifo_param;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

    logic          clock;
    logic          resetn;
    logic          flush;
    logic          wen;
    logic [DW-1:0] wdata;
    logic          ren;
    logic [DW-1:0] rdata;
    logic          full, empty, almost_full, almost_empty;
    logic [AW:0]   count;
    logic          overflow, underflow;

    int n_checks = 0;
    int n_fail   = 0;

    synch_fifo_param #(
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .AF_LEVEL (28),
        .AE_LEVEL (4)
    ) dut (
        .clock        (clock),
        .resetn       (resetn),
        .flush        (flush),
        .wen          (wen),
        .wdata        (wdata),
        .ren          (ren),
        .rdata        (rdata),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Reference model: a plain queue plus two sticky bits.
    logic [DW-1:0] mq[$];
    bit            m_ovf = 1'b0;
    bit            m_udf = 1'b0;

    initial begin
        forever begin
            @(posedge clock or negedge resetn);
            if (!resetn) begin
                mq.delete();
                m_ovf = 1'b0;
                m_udf = 1'b0;
            end else if (flush) begin
                mq.delete();
                m_ovf = 1'b0;
                m_udf = 1'b0;
            end else begin
                automatic bit was_full  = (mq.size() == DEPTH);
                automatic bit was_empty = (mq.size() == 0);
                if (wen && was_full)  m_ovf = 1'b1;
                if (ren && was_empty) m_udf = 1'b1;
                if (ren && !was_empty) void'(mq.pop_front());
                if (wen && !was_full)  mq.push_back(wdata);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of all outputs against the model.
    initial begin
        forever begin
            @(negedge clock);
            begin
                automatic int n = mq.size();
                check("m_count", 32'(count), 32'(n));
                check("m_empty", 32'(empty), 32'(n == 0));
                check("m_full",  32'(full),  32'(n == DEPTH));
                check("m_af",    32'(almost_full),  32'(n >= 28));
                check("m_ae",    32'(almost_empty), 32'(n <= 4));
                check("m_ovf",   32'(overflow),  32'(m_ovf));
                check("m_udf",   32'(underflow), 32'(m_udf));
                check("m_rdata", rdata, (n == 0) ? 32'h0 : mq[0]);
            end
        end
    end

    // One clock with the given controls; returns 1 time unit after the edge.
    task automatic step(input logic f, input logic w, input logic [DW-1:0] wd, input logic r);
        flush = f;
        wen   = w;
        wdata = wd;
        ren   = r;
        @(posedge clock);
        #1;
        flush = 1'b0;
        wen   = 1'b0;
        ren   = 1'b0;
        $display("txn f=%0b w=%0b wd=%08h r=%0b -> count=%0d rdata=%08h ovf=%0b udf=%0b",
                 f, w, wd, r, count, rdata, overflow, underflow);
    endtask

    initial begin
        resetn = 1'b0;
        flush  = 1'b0;
        wen    = 1'b0;
        ren    = 1'b0;
        wdata  = '0;

        // 1: reset state
        repeat (3) @(posedge clock);
        #1;
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full",  32'(full),  32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_ae",    32'(almost_empty), 32'd1);
        check("rst_af",    32'(almost_full),  32'd0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_ovf",   32'(overflow),  32'd0);
        check("rst_udf",   32'(underflow), 32'd0);
        resetn = 1'b1;

        // 2: fill to full, overflow, drain in order
        for (int i = 0; i < 32; i++) begin
            step(1'b0, 1'b1, 32'(i), 1'b0);
            if (i == 26) check("fill_af_27", 32'(almost_full), 32'd0);
            if (i == 27) check("fill_af_28", 32'(almost_full), 32'd1);
            if (i == 30) check("fill_full_31", 32'(full), 32'd0);
        end
        check("fill_full", 32'(full), 32'd1);
        check("fill_count", 32'(count), 32'd32);
        check("fill_head", rdata, 32'h0);
        step(1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
        check("ovf_count", 32'(count), 32'd32);
        check("ovf_flag",  32'(overflow), 32'd1);
        for (int i = 0; i < 32; i++) begin
            check("drain_data", rdata, 32'(i));
            step(1'b0, 1'b0, '0, 1'b1);
        end
        check("drain_empty", 32'(empty), 32'd1);
        check("drain_ovf_sticky", 32'(overflow), 32'd1);
        step(1'b1, 1'b0, '0, 1'b0);
        check("flush_ovf", 32'(overflow), 32'd0);

        // 3: wrap and concurrency
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 32'h100 + 32'(i), 1'b0);
        for (int i = 0; i < 20; i++) begin
            check("wrap_rd", rdata, 32'h100 + 32'(i));
            step(1'b0, 1'b0, '0, 1'b1);
        end
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 32'h200 + 32'(i), 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b1, 32'h300 + 32'(i), 1'b1);
            check("conc_count", 32'(count), 32'd3);
        end
        check("conc_head", rdata, 32'h311);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, 1'b1);
        check("conc_empty", 32'(empty), 32'd1);

        // 4: simultaneous read/write on empty
        step(1'b0, 1'b1, 32'hA5A5A5A5, 1'b1);
        check("ec_count", 32'(count), 32'd1);
        check("ec_rdata", rdata, 32'hA5A5A5A5);
        check("ec_udf",   32'(underflow), 32'd1);
        step(1'b1, 1'b0, '0, 1'b0);

        // 5: simultaneous read/write on full
        for (int i = 0; i < 32; i++) step(1'b0, 1'b1, 32'h400 + 32'(i), 1'b0);
        step(1'b0, 1'b1, 32'h0000CAFE, 1'b1);
        check("fc_count", 32'(count), 32'd31);
        check("fc_head",  rdata, 32'h401);
        check("fc_ovf",   32'(overflow), 32'd1);
        for (int i = 0; i < 31; i++) step(1'b0, 1'b0, '0, 1'b1);
        check("fc_empty", 32'(empty), 32'd1);
        step(1'b1, 1'b0, '0, 1'b0);

        // 6: flush with coincident write, then asynchronous reset mid-cycle
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 32'h500 + 32'(i), 1'b0);
        check("pre_flush_count", 32'(count), 32'd10);
        step(1'b1, 1'b1, 32'h12345678, 1'b0);
        check("flush_count", 32'(count), 32'd0);
        check("flush_empty", 32'(empty), 32'd1);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 32'h600 + 32'(i), 1'b0);
        check("refill_head", rdata, 32'h600);
        #2;
        resetn = 1'b0;
        #1;
        check("arst_empty", 32'(empty), 32'd1);
        check("arst_count", 32'(count), 32'd0);
        check("arst_rdata", rdata, 32'h0);
        @(posedge clock);
        #1;
        resetn = 1'b1;
        step(1'b0, 1'b1, 32'h77777777, 1'b0);
        check("post_rst_rdata", rdata, 32'h77777777);
        step(1'b0, 1'b0, '0, 1'b1);
        @(negedge clock);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_synch_fifo_param
